// File: rtl/beam_steering_sequencer.sv
// Purpose: loads host-programmed beam delay profiles into the beamformer's serial delay registers, single-shot or as a sweep.
// Latency: start -> dly_we=1 on the next clk edge; every bit is held until a committing ws_rise and advances one clk later.
// Backpressure: none; bit pacing is set purely by ws_rise, and stop aborts at once (priority over start and ws_rise).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   ws_rise                    one-clk pulse per ws_clk rising edge (clk domain)
//   cfg_we/beam/reg/delay      profile table write port, accepted in any state
//   start/sweep/start_beam     begin a single load (sweep=0) or a sweep (sweep=1) at start_beam
//   stop                       abort to IDLE
//   dwell_frames               ws frames spent on each beam in sweep (0 behaves as 1)
//   dly_sel/dly_data/dly_we    beamformer delay programming pins
//   busy, cur_beam, beam_loaded  status; beam_loaded pulses once per completed profile
module beam_steering_sequencer #(
  parameter int NUMBER_OF_CHANNELS = 4,
  parameter int BUFFER_SIZE        = 16,
  parameter int NUM_BEAMS          = 4,
  parameter int DWELL_WIDTH        = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    ws_rise,
  input  logic                                    cfg_we,
  input  logic [$clog2(NUM_BEAMS)-1:0]            cfg_beam,
  input  logic [$clog2(2*NUMBER_OF_CHANNELS)-1:0] cfg_reg,
  input  logic [$clog2(BUFFER_SIZE)-1:0]          cfg_delay,
  input  logic                                    start,
  input  logic                                    sweep,
  input  logic [$clog2(NUM_BEAMS)-1:0]            start_beam,
  input  logic                                    stop,
  input  logic [DWELL_WIDTH-1:0]                  dwell_frames,
  output logic [3:0]                              dly_sel,
  output logic                                    dly_data,
  output logic                                    dly_we,
  output logic                                    busy,
  output logic [$clog2(NUM_BEAMS)-1:0]            cur_beam,
  output logic                                    beam_loaded
);

  localparam int R     = 2 * NUMBER_OF_CHANNELS;
  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam int BW    = $clog2(NUM_BEAMS);
  localparam int RW    = $clog2(R);
  localparam int BIT_W = (IDX_W > 1) ? $clog2(IDX_W) : 1;

  localparam logic [RW-1:0]    LAST_REG = RW'(R - 1);
  localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(IDX_W - 1);
  localparam logic [BW-1:0]    LAST_BM  = BW'(NUM_BEAMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL
  } state_t;

  state_t                                  state_q, state_d;
  logic [BW-1:0]                           cur_beam_q, cur_beam_d;
  logic                                    sweep_q, sweep_d;
  logic [RW-1:0]                           r_q, r_d;
  logic [BIT_W-1:0]                        b_q, b_d;
  logic [IDX_W-1:0]                        holder_q, holder_d;
  logic [DWELL_WIDTH-1:0]                  frame_cnt_q, frame_cnt_d;
  logic [DWELL_WIDTH-1:0]                  dwell_tgt_q, dwell_tgt_d;
  logic                                    loaded_q, loaded_d;
  logic [NUM_BEAMS-1:0][R-1:0][IDX_W-1:0]  tbl_q, tbl_d;

  logic [RW-1:0] r_nxt;
  logic [BW-1:0] beam_nxt;

  assign r_nxt    = r_q + RW'(1);
  assign beam_nxt = (cur_beam_q == LAST_BM) ? '0 : cur_beam_q + BW'(1);

  // Register reads below use tbl_d, so a write on the same edge as a latch
  // is seen by that latch (write lands first).
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we) begin
      tbl_d[cfg_beam][cfg_reg] = cfg_delay;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_beam_d  = cur_beam_q;
    sweep_d     = sweep_q;
    r_d         = r_q;
    b_d         = b_q;
    holder_d    = holder_q;
    frame_cnt_d = frame_cnt_q;
    dwell_tgt_d = dwell_tgt_q;
    loaded_d    = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_LOAD;
            cur_beam_d = start_beam;
            sweep_d    = sweep;
            r_d        = '0;
            b_d        = TOP_BIT;
            holder_d   = tbl_d[start_beam][0];
          end
        end

        S_LOAD: begin
          // ws_rise while dly_we is high commits the bit currently on dly_data.
          if (ws_rise) begin
            if (b_q == '0) begin
              if (r_q == LAST_REG) begin
                loaded_d = 1'b1;
                if (sweep_q) begin
                  state_d     = S_DWELL;
                  frame_cnt_d = '0;
                  dwell_tgt_d = (dwell_frames == '0) ? DWELL_WIDTH'(1) : dwell_frames;
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                r_d      = r_nxt;
                b_d      = TOP_BIT;
                holder_d = tbl_d[cur_beam_q][r_nxt];
              end
            end else begin
              b_d = b_q - BIT_W'(1);
            end
          end
        end

        S_DWELL: begin
          if (ws_rise) begin
            if (frame_cnt_q + DWELL_WIDTH'(1) == dwell_tgt_q) begin
              state_d    = S_LOAD;
              cur_beam_d = beam_nxt;
              r_d        = '0;
              b_d        = TOP_BIT;
              holder_d   = tbl_d[beam_nxt][0];
            end else begin
              frame_cnt_d = frame_cnt_q + DWELL_WIDTH'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_beam_q  <= '0;
      sweep_q     <= 1'b0;
      r_q         <= '0;
      b_q         <= '0;
      holder_q    <= '0;
      frame_cnt_q <= '0;
      dwell_tgt_q <= '0;
      loaded_q    <= 1'b0;
      tbl_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_beam_q  <= cur_beam_d;
      sweep_q     <= sweep_d;
      r_q         <= r_d;
      b_q         <= b_d;
      holder_q    <= holder_d;
      frame_cnt_q <= frame_cnt_d;
      dwell_tgt_q <= dwell_tgt_d;
      loaded_q    <= loaded_d;
      tbl_q       <= tbl_d;
    end
  end

  // Pins are driven straight from flops, so they only move on the clk after
  // a commit; outside LOAD select/data are parked at 0.
  always_comb begin
    dly_sel  = '0;
    dly_data = 1'b0;
    if (state_q == S_LOAD) begin
      dly_sel[RW-1:0] = r_q;
      dly_data        = holder_q[b_q];
    end
  end

  assign dly_we      = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign cur_beam    = cur_beam_q;
  assign beam_loaded = loaded_q;

endmodule

// File: doc/beam_steering_sequencer.md
# beam_steering_sequencer

Sequencer that loads per-beam delay sets into the beamformer's serial delay registers (select / data / write-enable shift interface, sampled on ws_clk rising edge). It holds a host-written table of NUM_BEAMS beam profiles and either loads one profile on command or sweeps all profiles, dwelling a programmable number of ws frames on each. It sits between the host configuration port and the beamformer's uio_in[5:0] delay-programming pins.

## Interface
- NUMBER_OF_CHANNELS, 4, stereo I2S inputs; delay register count R = 2*NUMBER_OF_CHANNELS
- BUFFER_SIZE, 16, channel buffer depth; delay width IDX_W = $clog2(BUFFER_SIZE)
- NUM_BEAMS, 4, profiles in the table; BW = $clog2(NUM_BEAMS)
- DWELL_WIDTH, 8, width of dwell_frames

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset
- ws_rise  in  1  one-clk pulse, clk-synchronous, marking each ws_clk rising edge
- cfg_we  in  1  table write strobe
- cfg_beam  in  BW  table profile index
- cfg_reg  in  $clog2(R)  delay register index within profile
- cfg_delay  in  IDX_W  delay value
- start  in  1  begin load/sweep (pulse)
- sweep  in  1  mode, sampled with start: 0 single, 1 sweep
- start_beam  in  BW  first profile, sampled with start
- stop  in  1  abort
- dwell_frames  in  DWELL_WIDTH  frames per beam in sweep, sampled at each DWELL entry
- dly_sel  out  4  delay register select (upper unused bits 0)
- dly_data  out  1  serial delay bit, MSB first
- dly_we  out  1  delay write enable
- busy  out  1  state != IDLE
- cur_beam  out  BW  profile being loaded / dwelt on
- beam_loaded  out  1  one-clk pulse when a full profile has been shifted in

## Operation
- Table: NUM_BEAMS x R entries of IDX_W bits; cleared to 0 on reset. cfg_we writes table[cfg_beam][cfg_reg] <= cfg_delay on the same edge, in any state.
- States: IDLE, LOAD, DWELL.
- IDLE: start=1 -> LOAD, cur_beam <= start_beam, latch sweep mode, reg index r <= 0, bit index b <= IDX_W-1. start while busy is ignored.
- LOAD: at start of each register (b = IDX_W-1) the entry table[cur_beam][r] is latched into a shift holder; later table writes affect that register only if made before its latch. Outputs: dly_sel = r, dly_data = holder[b], dly_we = 1.
  - A bit is committed when ws_rise=1 with dly_we=1. Next cycle: b decrements; at b=0 advance r, reload holder, b <= IDX_W-1.
  - Commit of last bit of r = R-1: next cycle dly_we=0, beam_loaded=1 for one cycle; single mode -> IDLE, sweep mode -> DWELL with frame counter 0.
- DWELL: dly_we=0; count ws_rise pulses; after max(dwell_frames,1) pulses -> LOAD with cur_beam+1, wrapping NUM_BEAMS-1 -> 0.
- stop=1 in any state: next cycle IDLE, dly_we=0; a partially shifted register keeps the partial value in the beamformer (host must reload). stop has priority over start and ws_rise in the same cycle.
- cfg_we and start in the same cycle: write lands first; the load observes it if it targets register 0 of start_beam.

## Timing
- Reset values: dly_sel=0, dly_data=0, dly_we=0, busy=0, cur_beam=0, beam_loaded=0; state IDLE; counters 0; table 0.
- start -> LOAD and dly_we=1 on the following clk edge (1-cycle latency).
- Outputs change only the cycle after a committing ws_rise, so each bit is stable across a full ws period before the beamformer's next sampling edge.
- Full profile load = R*IDX_W ws_rise pulses (32 for defaults); ws_rise at the first LOAD cycle counts.
- Sweep period per beam = R*IDX_W + max(dwell_frames,1) ws_rise pulses.
- Reset mid-operation: all of the above reset values apply on the next edge regardless of state.

## Test plan
- Reset -> all outputs 0, busy=0; table readback via single load of beam 0 shifts 32 zero bits on sel 0..7.
- Write beam 2 reg 5 = 4'b1011, others 0; start sweep=0 start_beam=2, ws_rise every 32 clk -> on sel=5 dly_data sequence 1,0,1,1; beam_loaded pulse after 32nd ws_rise; busy falls next cycle.
- Sweep, start_beam=3, dwell_frames=2 -> loads beam 3, 2 dwell frames, then cur_beam=0 (wrap), beam_loaded pulses every 34 ws_rise.
- dwell_frames=0 -> dwell of exactly 1 frame.
- stop asserted during bit 2 of reg 3 together with start and ws_rise -> next cycle IDLE, dly_we=0, no beam_loaded; start ignored.
- cfg_we to current beam's reg 6 while reg 2 is shifting -> new value shifted for reg 6; write to reg 1 after its latch -> old value shifted.
